// File: rtl/debounce_pkg.sv
// Shared types and default timing for the button debouncer family.
//   state_t         : per-channel FSM state encoding
//   DEF_*           : default timing constants (clock cycles)
//   max3()          : helper used to size the shared per-channel down-counter
package debounce_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMING,
        S_PRESSED,
        S_REPEATING,
        S_RELEASING
    } state_t;

    localparam int DEF_N_CH            = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_HOLD_CYCLES     = 50000000;
    localparam int DEF_REPEAT_CYCLES   = 10000000;
    localparam int DEF_REPEAT_EN       = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button channel: 2-flop synchroniser, stability-window FSM
// and a single shared down-counter used for debounce, hold and repeat timing.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   btn_i        : raw asynchronous button, active-high
//   level_o      : debounced level
//   press_o      : one-cycle pulse on accepted 0->1
//   release_o    : one-cycle pulse on accepted 1->0
//   repeat_o     : one-cycle auto-repeat pulse while held
//   state_o      : current FSM state, for debug visibility
// Pulse outputs carry no handshake: each is a registered single-cycle strobe
// that downstream logic must sample on the cycle it is high.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int REPEAT_EN       = DEF_REPEAT_EN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_i,
    output logic       level_o,
    output logic       press_o,
    output logic       release_o,
    output logic       repeat_o,
    output logic [2:0] state_o
);

    localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DEB_LOAD  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LOAD  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    logic             sync_q1, sync_q2;
    logic             sync;
    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             level_q, level_n;
    logic             press_q, press_n;
    logic             release_q, release_n;
    logic             repeat_q, repeat_n;

    assign sync = sync_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1   <= 1'b0;
            sync_q2   <= 1'b0;
            state_q   <= S_IDLE;
            cnt_q     <= CNT_ZERO;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            sync_q1   <= btn_i;
            sync_q2   <= sync_q1;
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            level_q   <= level_n;
            press_q   <= press_n;
            release_q <= release_n;
            repeat_q  <= repeat_n;
        end
    end

    // The counter is only ever decremented on a nonzero value, so it cannot wrap.
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        level_n   = level_q;
        press_n   = 1'b0;
        release_n = 1'b0;
        repeat_n  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sync) begin
                    state_n = S_ARMING;
                    cnt_n   = DEB_LOAD;
                end
            end
            S_ARMING: begin
                if (!sync) begin
                    state_n = S_IDLE;
                end else if (cnt_q == CNT_ZERO) begin
                    state_n = S_PRESSED;
                    level_n = 1'b1;
                    press_n = 1'b1;
                    cnt_n   = HOLD_LOAD;
                end else begin
                    cnt_n = cnt_q - CNT_ONE;
                end
            end
            S_PRESSED, S_REPEATING: begin
                if (!sync) begin
                    state_n = S_RELEASING;
                    cnt_n   = DEB_LOAD;
                end else if (cnt_q == CNT_ZERO) begin
                    // With repeat disabled the counter simply parks at zero.
                    if (REPEAT_EN != 0) begin
                        state_n  = S_REPEATING;
                        repeat_n = 1'b1;
                        cnt_n    = REP_LOAD;
                    end
                end else begin
                    cnt_n = cnt_q - CNT_ONE;
                end
            end
            S_RELEASING: begin
                if (sync) begin
                    // Glitch during release: stay pressed, hold timer restarts.
                    state_n = S_PRESSED;
                    cnt_n   = HOLD_LOAD;
                end else if (cnt_q == CNT_ZERO) begin
                    state_n   = S_IDLE;
                    level_n   = 1'b0;
                    release_n = 1'b1;
                end else begin
                    cnt_n = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = CNT_ZERO;
                level_n = 1'b0;
            end
        endcase
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign repeat_o  = repeat_q;
    assign state_o   = state_q;

endmodule

// File: rtl/multi_button_debouncer.sv
// N_CH independent button debouncers with level, press, release and
// auto-repeat outputs.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   btn_i       : raw asynchronous buttons, active-high
//   level_o     : debounced levels
//   press_o     : one-cycle press pulses
//   release_o   : one-cycle release pulses
//   repeat_o    : one-cycle auto-repeat pulses
//   state_o     : per-channel FSM state, 3 bits per channel (debug)
module multi_button_debouncer
    import debounce_pkg::*;
#(
    parameter int N_CH            = DEF_N_CH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int REPEAT_EN       = DEF_REPEAT_EN
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CH-1:0]     btn_i,
    output logic [N_CH-1:0]     level_o,
    output logic [N_CH-1:0]     press_o,
    output logic [N_CH-1:0]     release_o,
    output logic [N_CH-1:0]     repeat_o,
    output logic [3*N_CH-1:0]   state_o
);

    for (genvar i = 0; i < N_CH; i++) begin : gen_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .REPEAT_EN       (REPEAT_EN)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .btn_i     (btn_i[i]),
            .level_o   (level_o[i]),
            .press_o   (press_o[i]),
            .release_o (release_o[i]),
            .repeat_o  (repeat_o[i]),
            .state_o   (state_o[3*i +: 3])
        );
    end

endmodule
